bsg_trace_recorder: RTL and testbench



---
 rtl/bsg_trace_recorder.sv | 151 +++++++++++++++
 tb/tb_bsg_trace_recorder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_trace_recorder.sv
// Channel sink that records DUT packets as {op, payload} trace records.
// Idle gaps become CycleInit/CycleDec pairs; finish closes with Done/Finish.
module bsg_trace_recorder
  #(parameter int payload_width_p  = 80
   ,parameter int rom_addr_width_p = 6
   ,parameter int counter_width_p  =
      (payload_width_p < 16) ? payload_width_p : 16
   )
  (input  logic                          clk_i
  ,input  logic                          reset_n_i
  ,input  logic                          en_i
  ,input  logic                          v_i
  ,input  logic [payload_width_p-1:0]    data_i
  ,output logic                          ready_o
  ,input  logic                          finish_i
  ,output logic                          mem_v_o
  ,output logic [rom_addr_width_p-1:0]   mem_addr_o
  ,output logic [payload_width_p+4-1:0]  mem_data_o
  ,output logic                          done_o
  ,output logic                          error_o
  );

  localparam logic [2:0] s_cap    = 3'd0;
  localparam logic [2:0] s_w_dec  = 3'd1;
  localparam logic [2:0] s_w_data = 3'd2;
  localparam logic [2:0] s_w_done = 3'd3;
  localparam logic [2:0] s_w_fin  = 3'd4;
  localparam logic [2:0] s_done   = 3'd5;

  localparam logic [3:0] op_receive = 4'd2;
  localparam logic [3:0] op_done    = 4'd3;
  localparam logic [3:0] op_finish  = 4'd4;
  localparam logic [3:0] op_cyc_dec = 4'd5;
  localparam logic [3:0] op_cyc_ini = 4'd6;

  localparam int unsigned depth_lp = 1 << rom_addr_width_p;
  // Last address that still leaves 3 slots for a Receive plus 2 for closing.
  localparam logic [rom_addr_width_p-1:0] room_max_lp =
    rom_addr_width_p'(depth_lp - 5);

  logic [2:0]                   state_r, state_n;
  logic [rom_addr_width_p-1:0]  addr_r;
  logic [counter_width_p-1:0]   gap_r, gap_n;
  logic [payload_width_p-1:0]   hold_r, hold_n;
  logic                         gap_only_r, gap_only_n;
  logic                         error_r, error_n;

  logic                         room, gap_full, hs, wr;
  logic [3:0]                   op;
  logic [payload_width_p-1:0]   pay;

  assign room     = (addr_r <= room_max_lp);
  assign gap_full = &gap_r;
  assign ready_o  = reset_n_i & (state_r == s_cap)
                  & en_i & ~finish_i & room;
  assign hs       = v_i & ready_o;

  always_comb begin
    state_n    = state_r;
    gap_n      = gap_r;
    hold_n     = hold_r;
    gap_only_n = gap_only_r;
    error_n    = error_r;
    wr         = 1'b0;
    op         = op_receive;
    pay        = '0;
    unique case (state_r)
      s_cap: begin
        if (hs && (gap_r == '0)) begin
          wr  = 1'b1;
          pay = data_i;
        end else if (hs) begin
          wr         = 1'b1;
          op         = op_cyc_ini;
          pay        = payload_width_p'(gap_r);
          hold_n     = data_i;
          gap_n      = '0;
          gap_only_n = 1'b0;
          state_n    = s_w_dec;
        end else if (en_i & room & gap_full) begin
          wr         = 1'b1;
          op         = op_cyc_ini;
          pay        = payload_width_p'(gap_r);
          gap_n      = '0;
          gap_only_n = 1'b1;
          state_n    = s_w_dec;
        end else if (en_i & finish_i) begin
          gap_n   = '0;
          state_n = s_w_done;
        end else if (en_i & ~room) begin
          error_n = 1'b1;
          state_n = s_w_done;
        end else if (en_i) begin
          gap_n = gap_r + counter_width_p'(1);
        end
      end
      s_w_dec: begin
        wr      = 1'b1;
        op      = op_cyc_dec;
        state_n = gap_only_r ? s_cap : s_w_data;
      end
      s_w_data: begin
        wr      = 1'b1;
        pay     = hold_r;
        state_n = s_cap;
      end
      s_w_done: begin
        wr      = 1'b1;
        op      = op_done;
        state_n = s_w_fin;
      end
      s_w_fin: begin
        wr      = 1'b1;
        op      = op_finish;
        state_n = s_done;
      end
      s_done: begin
        state_n = s_done;
      end
      default: begin
        state_n = s_cap;
      end
    endcase
  end

  assign mem_v_o    = reset_n_i & wr;
  assign mem_addr_o = addr_r;
  assign mem_data_o = {op, pay};
  assign done_o     = (state_r == s_done);
  assign error_o    = error_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= s_cap;
      addr_r     <= '0;
      gap_r      <= '0;
      hold_r     <= '0;
      gap_only_r <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_n;
      gap_r      <= gap_n;
      hold_r     <= hold_n;
      gap_only_r <= gap_only_n;
      error_r    <= error_n;
      if (wr)
        addr_r <= addr_r + rom_addr_width_p'(1);
    end
  end

endmodule

// File: tb/tb_bsg_trace_recorder.sv
// Scoreboard bench for bsg_trace_recorder: default build plus a small
// build (depth 8, 3-bit gap counter) for overflow and saturation.
module tb_bsg_trace_recorder;

  typedef struct packed {
    logic [5:0]  addr;
    logic [83:0] data;
  } rec_t;

  logic        clk;
  logic        rst_a_n, rst_b_n;
  logic        en, v, finish;
  logic [79:0] data;

  logic        ready_a, mem_v_a, done_a, error_a;
  logic [5:0]  mem_addr_a;
  logic [83:0] mem_data_a;
  logic        ready_b, mem_v_b, done_b, error_b;
  logic [2:0]  mem_addr_b;
  logic [83:0] mem_data_b;

  int n_cmp = 0;
  int n_bad = 0;

  rec_t qa[$];
  rec_t qb[$];
  rec_t ea, eb;

  bsg_trace_recorder dut_a
    (.clk_i(clk), .reset_n_i(rst_a_n), .en_i(en), .v_i(v)
    ,.data_i(data), .ready_o(ready_a), .finish_i(finish)
    ,.mem_v_o(mem_v_a), .mem_addr_o(mem_addr_a)
    ,.mem_data_o(mem_data_a), .done_o(done_a), .error_o(error_a));

  bsg_trace_recorder
    #(.payload_width_p(80), .rom_addr_width_p(3), .counter_width_p(3))
  dut_b
    (.clk_i(clk), .reset_n_i(rst_b_n), .en_i(en), .v_i(v)
    ,.data_i(data), .ready_o(ready_b), .finish_i(finish)
    ,.mem_v_o(mem_v_b), .mem_addr_o(mem_addr_b)
    ,.mem_data_o(mem_data_b), .done_o(done_b), .error_o(error_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t mk(int a, logic [3:0] op, logic [79:0] p);
    rec_t r;
    r.addr = a[5:0];
    r.data = {op, p};
    return r;
  endfunction

  function automatic void chkv(string nm, logic [95:0] act,
                               logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void chk1(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endfunction

  function automatic void chkn(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_a_n && mem_v_a) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rec_a unexpected: got addr %0d data %h expected none",
                 mem_addr_a, mem_data_a);
      end else begin
        ea = qa.pop_front();
        chkv("rec_a", 96'({mem_addr_a, mem_data_a}),
             96'({ea.addr, ea.data}));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b_n && mem_v_b) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rec_b unexpected: got addr %0d data %h expected none",
                 mem_addr_b, mem_data_b);
      end else begin
        eb = qb.pop_front();
        chkv("rec_b", 96'({3'b000, mem_addr_b, mem_data_b}),
             96'({eb.addr, eb.data}));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    en      = 1'b1;
    v       = 1'b1;
    finish  = 1'b0;
    data    = '0;

    // reset state, with en/v high to show outputs stay quiet
    tick;
    tick;
    @(negedge clk);
    chk1("rst_ready_a", ready_a, 1'b0);
    chk1("rst_memv_a", mem_v_a, 1'b0);
    chk1("rst_done_a", done_a, 1'b0);
    chk1("rst_err_a", error_a, 1'b0);
    chk1("rst_ready_b", ready_b, 1'b0);
    chk1("rst_memv_b", mem_v_b, 1'b0);
    tick;

    // back-to-back capture
    rst_a_n = 1'b1;
    qa.push_back(mk(0, 4'd2, 80'h1));
    qa.push_back(mk(1, 4'd2, 80'h2));
    qa.push_back(mk(2, 4'd2, 80'h3));
    for (int i = 1; i <= 3; i++) begin
      data = 80'(i);
      @(negedge clk);
      chk1("b2b_ready", ready_a, 1'b1);
      tick;
    end
    v  = 1'b0;
    en = 1'b0;
    tick;
    chkn("b2b_drain", qa.size(), 0);

    // gap encoding then finish
    rst_a_n = 1'b0;
    tick;
    rst_a_n = 1'b1;
    en   = 1'b1;
    v    = 1'b1;
    data = 80'hA;
    qa.push_back(mk(0, 4'd2, 80'hA));
    tick;
    v = 1'b0;
    repeat (4) tick;
    v    = 1'b1;
    data = 80'hB;
    qa.push_back(mk(1, 4'd6, 80'h4));
    qa.push_back(mk(2, 4'd5, 80'h0));
    qa.push_back(mk(3, 4'd2, 80'hB));
    @(negedge clk);
    chk1("gap_ready_hs", ready_a, 1'b1);
    tick;
    v = 1'b0;
    @(negedge clk);
    chk1("gap_ready_dec", ready_a, 1'b0);
    tick;
    @(negedge clk);
    chk1("gap_ready_data", ready_a, 1'b0);
    tick;
    finish = 1'b1;
    qa.push_back(mk(4, 4'd3, 80'h0));
    qa.push_back(mk(5, 4'd4, 80'h0));
    @(negedge clk);
    chk1("fin_ready", ready_a, 1'b0);
    chk1("fin_done_t0", done_a, 1'b0);
    tick;
    @(negedge clk);
    chk1("fin_done_t1", done_a, 1'b0);
    tick;
    @(negedge clk);
    chk1("fin_done_t2", done_a, 1'b0);
    tick;
    @(negedge clk);
    chk1("fin_done_t3", done_a, 1'b1);
    finish = 1'b0;
    v      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data = 80'(32 + i);
      tick;
      @(negedge clk);
      chk1("done_ready", ready_a, 1'b0);
      chk1("done_hold", done_a, 1'b1);
    end
    chk1("fin_err", error_a, 1'b0);
    v  = 1'b0;
    en = 1'b0;
    tick;
    chkn("gap_drain", qa.size(), 0);

    // reset in W_DEC, then en_i gating
    rst_a_n = 1'b0;
    tick;
    rst_a_n = 1'b1;
    en   = 1'b1;
    v    = 1'b1;
    data = 80'h5;
    qa.push_back(mk(0, 4'd2, 80'h5));
    tick;
    v = 1'b0;
    tick;
    v    = 1'b1;
    data = 80'h6;
    qa.push_back(mk(1, 4'd6, 80'h1));
    tick;
    chk1("wdec_memv", mem_v_a, 1'b1);
    rst_a_n = 1'b0;
    #1;
    chk1("mid_rst_memv", mem_v_a, 1'b0);
    chk1("mid_rst_ready", ready_a, 1'b0);
    chk1("mid_rst_done", done_a, 1'b0);
    chk1("mid_rst_addr0", mem_addr_a == 6'd0, 1'b1);
    tick;
    rst_a_n = 1'b1;
    en   = 1'b0;
    v    = 1'b1;
    data = 80'h7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("en0_ready", ready_a, 1'b0);
      tick;
    end
    en = 1'b1;
    qa.push_back(mk(0, 4'd2, 80'h7));
    @(negedge clk);
    chk1("en1_ready", ready_a, 1'b1);
    tick;
    v  = 1'b0;
    en = 1'b0;
    tick;
    chkn("rst_drain", qa.size(), 0);

    // overflow on depth-8 build
    rst_a_n = 1'b0;
    tick;
    rst_b_n = 1'b1;
    en = 1'b1;
    v  = 1'b1;
    for (int i = 0; i < 4; i++)
      qb.push_back(mk(i, 4'd2, 80'(16 + i)));
    qb.push_back(mk(4, 4'd3, 80'h0));
    qb.push_back(mk(5, 4'd4, 80'h0));
    for (int i = 0; i < 8; i++) begin
      data = 80'(16 + i);
      @(negedge clk);
      chk1("ovf_ready", ready_b, i < 4);
      chk1("ovf_error", error_b, i >= 5);
      chk1("ovf_done", done_b, i >= 7);
      tick;
    end
    v  = 1'b0;
    en = 1'b0;
    tick;
    chkn("ovf_drain", qb.size(), 0);

    // gap counter saturation, then restart from zero
    rst_b_n = 1'b0;
    tick;
    rst_b_n = 1'b1;
    en = 1'b1;
    v  = 1'b0;
    qb.push_back(mk(0, 4'd6, 80'h7));
    qb.push_back(mk(1, 4'd5, 80'h0));
    qb.push_back(mk(2, 4'd6, 80'h2));
    qb.push_back(mk(3, 4'd5, 80'h0));
    qb.push_back(mk(4, 4'd2, 80'h55));
    repeat (7) tick;
    @(negedge clk);
    chk1("sat_emit", mem_v_b, 1'b1);
    tick;
    @(negedge clk);
    chk1("sat_dec_ready", ready_b, 1'b0);
    tick;
    tick;
    tick;
    v    = 1'b1;
    data = 80'h55;
    tick;
    v  = 1'b0;
    en = 1'b0;
    repeat (4) tick;
    chkn("sat_drain", qb.size(), 0);
    chk1("sat_err", error_b, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
